// File: rtl/dbg_stream_host_if.sv
`default_nettype none
// ============================================================================
// dbg_stream_host_if : host byte link + SoC debug port bundle   (rev 1.0)
// ============================================================================
interface dbg_stream_host_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  dbg_cmd_o;
  logic [31:0] dbg_addr_o;
  logic [31:0] dbg_data_o;
  logic [31:0] dbg_data_i;
  logic        dbg_ready_i;
  logic        busy_o;

  // slave is the bridge itself; master is the link FIFOs plus debug responder
  modport slave (
    input  rx_data_i, rx_valid_i, tx_ready_i, dbg_data_i, dbg_ready_i,
    output rx_ready_o, tx_data_o, tx_valid_o, dbg_cmd_o, dbg_addr_o, dbg_data_o, busy_o
  );

  modport master (
    output rx_data_i, rx_valid_i, tx_ready_i, dbg_data_i, dbg_ready_i,
    input  rx_ready_o, tx_data_o, tx_valid_o, dbg_cmd_o, dbg_addr_o, dbg_data_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/dbg_stream_host.sv
`default_nettype none
// ============================================================================
// dbg_stream_host : 9-byte request frames -> debug port, 5-byte responses   (rev 1.0)
// ============================================================================
module dbg_stream_host #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RX_GAP_CYCLES  = 65536
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  dbg_stream_host_if.slave bus
);
  localparam int c_tmo_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int c_gap_w = (RX_GAP_CYCLES > 1) ? $clog2(RX_GAP_CYCLES) : 1;
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(RX_GAP_CYCLES - 1);
  localparam logic [7:0] c_st_ok  = 8'h00;
  localparam logic [7:0] c_st_inv = 8'hE1;
  localparam logic [7:0] c_st_tmo = 8'hEE;

  typedef enum logic [1:0] {
    ST_RX      = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_TX      = 2'd3
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [c_gap_w-1:0]  r_gap;
  logic [c_tmo_w-1:0]  r_tmo;
  logic [7:0]          r_cmd;
  logic [31:0]         r_addr;
  logic [31:0]         r_data;
  logic [7:0]          r_status;
  logic [31:0]         r_rdata;
  logic                r_rx_ready;
  logic                r_tx_valid;
  logic [7:0]          r_tx_data;
  logic [7:0]          r_dbg_cmd;
  logic [31:0]         r_dbg_addr;
  logic [31:0]         r_dbg_data;
  logic                w_rx_fire;
  logic [7:0]          w_next_byte;

  assign w_rx_fire = bus.rx_valid_i && r_rx_ready;

  // In TX, r_cnt is the index of the byte on the wire; the one after it is RDATA byte r_cnt
  always_comb begin
    w_next_byte = 8'h00;
    case (r_cnt[1:0])
      2'd0:    w_next_byte = r_rdata[7:0];
      2'd1:    w_next_byte = r_rdata[15:8];
      2'd2:    w_next_byte = r_rdata[23:16];
      default: w_next_byte = r_rdata[31:24];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_RX;
      r_cnt      <= 4'd0;
      r_gap      <= '0;
      r_tmo      <= '0;
      r_cmd      <= 8'h00;
      r_addr     <= 32'h0;
      r_data     <= 32'h0;
      r_status   <= 8'h00;
      r_rdata    <= 32'h0;
      r_rx_ready <= 1'b1;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_dbg_cmd  <= 8'h00;
      r_dbg_addr <= 32'h0;
      r_dbg_data <= 32'h0;
    end else begin
      case (r_state)
        ST_RX: begin
          if (w_rx_fire) begin
            r_gap <= '0;
            case (r_cnt)
              4'd0:    r_cmd          <= bus.rx_data_i;
              4'd1:    r_addr[7:0]    <= bus.rx_data_i;
              4'd2:    r_addr[15:8]   <= bus.rx_data_i;
              4'd3:    r_addr[23:16]  <= bus.rx_data_i;
              4'd4:    r_addr[31:24]  <= bus.rx_data_i;
              4'd5:    r_data[7:0]    <= bus.rx_data_i;
              4'd6:    r_data[15:8]   <= bus.rx_data_i;
              4'd7:    r_data[23:16]  <= bus.rx_data_i;
              default: r_data[31:24]  <= bus.rx_data_i;
            endcase
            if (r_cnt == 4'd8) begin
              r_cnt      <= 4'd0;
              r_rx_ready <= 1'b0;
              if (r_cmd == 8'h00) begin
                r_state    <= ST_TX;
                r_status   <= c_st_inv;
                r_rdata    <= 32'h0;
                r_tx_data  <= c_st_inv;
                r_tx_valid <= 1'b1;
              end else begin
                r_state    <= ST_ISSUE;
                r_tmo      <= '0;
                r_dbg_cmd  <= r_cmd;
                r_dbg_addr <= r_addr;
                r_dbg_data <= {bus.rx_data_i, r_data[23:0]};
              end
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end else if (r_cnt != 4'd0) begin
            // A stalled partial frame is dropped silently so the next frame realigns
            if (r_gap == c_gap_last) begin
              r_cnt <= 4'd0;
              r_gap <= '0;
            end else begin
              r_gap <= r_gap + c_gap_w'(1);
            end
          end
        end

        ST_ISSUE: begin
          r_tmo <= r_tmo + c_tmo_w'(1);
          if (bus.dbg_ready_i) begin
            r_rdata   <= bus.dbg_data_i;
            r_status  <= c_st_ok;
            r_dbg_cmd <= 8'h00;
            r_state   <= ST_RELEASE;
          end else if (r_tmo == c_tmo_last) begin
            r_rdata   <= 32'h0;
            r_status  <= c_st_tmo;
            r_dbg_cmd <= 8'h00;
            r_state   <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          r_tmo <= '0;
          if (!bus.dbg_ready_i) begin
            r_state    <= ST_TX;
            r_cnt      <= 4'd0;
            r_tx_data  <= r_status;
            r_tx_valid <= 1'b1;
          end
        end

        ST_TX: begin
          if (r_tx_valid && bus.tx_ready_i) begin
            if (r_cnt == 4'd4) begin
              r_state    <= ST_RX;
              r_cnt      <= 4'd0;
              r_tx_valid <= 1'b0;
              r_tx_data  <= 8'h00;
              r_rx_ready <= 1'b1;
            end else begin
              r_cnt     <= r_cnt + 4'd1;
              r_tx_data <= w_next_byte;
            end
          end
        end

        default: r_state <= ST_RX;
      endcase
    end
  end

  assign bus.rx_ready_o = r_rx_ready;
  assign bus.tx_valid_o = r_tx_valid;
  assign bus.tx_data_o  = r_tx_data;
  assign bus.dbg_cmd_o  = r_dbg_cmd;
  assign bus.dbg_addr_o = r_dbg_addr;
  assign bus.dbg_data_o = r_dbg_data;
  assign bus.busy_o     = (r_state != ST_RX) || (r_cnt != 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_dbg_stream_host.sv
`default_nettype none
// ============================================================================
// tb_dbg_stream_host : randomized frames checked against a transaction-level model   (rev 1.0)
// ============================================================================
module tb_dbg_stream_host;
  localparam int TMO = 16;
  localparam int GAP = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dbg_stream_host_if bus ();

  dbg_stream_host #(
    .TIMEOUT_CYCLES(TMO),
    .RX_GAP_CYCLES (GAP)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sends the first nbytes of a frame; returns at the negedge after the last byte is taken
  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input int nbytes);
    logic [71:0] fr;
    int          accepted;
    fr       = {data, addr, cmd};
    accepted = 0;
    for (int i = 0; i < nbytes; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.rx_data_i  = fr[8*i +: 8];
      bus.rx_valid_i = 1'b1;
      for (int w = 0; w < 20; w++) begin
        logic rdy;
        rdy = bus.rx_ready_o;
        @(negedge clk);
        if (rdy) begin
          accepted++;
          break;
        end
      end
      bus.rx_valid_i = 1'b0;
      bus.rx_data_i  = 8'($urandom);
    end
    check_eq("rx_accept", 64'(accepted), 64'(nbytes));
  endtask

  // d: responder raises ready in the d-th cycle the command is visible (d>TMO: never)
  // h: extra cycles the responder keeps ready high after the command goes idle
  task automatic run_txn(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                         input int d, input int h, input logic [31:0] rdata);
    logic [7:0]  exp_rsp [5];
    logic [7:0]  got [$];
    logic [31:0] rd_exp;
    logic [7:0]  prev_data;
    bit          issued, ok, ready_on, prev_stall, done;
    int          exp_active, exp_first;
    int          active, seen, hold_left, first, bad_hold, bad_stall, bad_rx;

    issued     = (cmd != 8'h00);
    ok         = issued && (d >= 1) && (d <= TMO);
    exp_active = !issued ? 0 : (ok ? d : TMO);
    exp_first  = !issued ? 0 : (ok ? d + 1 + h : TMO + 1);
    rd_exp     = ok ? rdata : 32'h0;
    exp_rsp[0] = !issued ? 8'hE1 : (ok ? 8'h00 : 8'hEE);
    for (int i = 0; i < 4; i++) exp_rsp[i+1] = 8'((rd_exp >> (8*i)) & 32'hFF);

    active = 0; seen = 0; hold_left = 0; first = -1;
    bad_hold = 0; bad_stall = 0; bad_rx = 0;
    ready_on = 0; prev_stall = 0; done = 0; prev_data = 8'h00;

    send_frame(cmd, addr, data, 9);

    for (int k = 0; k < 200 && !done; k++) begin
      if (bus.rx_ready_o) bad_rx++;
      bus.rx_valid_i = 1'($urandom_range(0, 1));
      if (bus.dbg_cmd_o != 8'h00) begin
        active++;
        seen++;
        if (bus.dbg_cmd_o !== cmd || bus.dbg_addr_o !== addr || bus.dbg_data_o !== data)
          bad_hold++;
      end
      if (bus.dbg_cmd_o != 8'h00 && seen == d) begin
        bus.dbg_ready_i = 1'b1;
        bus.dbg_data_i  = rdata;
        ready_on        = 1;
        hold_left       = h;
      end else begin
        bus.dbg_data_i = $urandom;
        if (ready_on && bus.dbg_cmd_o == 8'h00) begin
          if (hold_left == 0) begin
            bus.dbg_ready_i = 1'b0;
            ready_on        = 0;
          end else begin
            hold_left--;
          end
        end
      end
      if (bus.tx_valid_o) begin
        if (first < 0) first = k;
        if (prev_stall && bus.tx_data_o !== prev_data) bad_stall++;
        bus.tx_ready_i = 1'($urandom_range(0, 1));
        if (bus.tx_ready_i) got.push_back(bus.tx_data_o);
        prev_stall = !bus.tx_ready_i;
        prev_data  = bus.tx_data_o;
      end else begin
        prev_stall     = 0;
        bus.tx_ready_i = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (got.size() == 5) done = 1;
    end
    bus.tx_ready_i  = 1'b0;
    bus.dbg_ready_i = 1'b0;
    bus.rx_valid_i  = 1'b0;

    check_eq("tx_done",     64'(done),      64'(1));
    check_eq("cmd_cycles",  64'(active),    64'(exp_active));
    check_eq("cmd_hold",    64'(bad_hold),  64'(0));
    check_eq("rsp_latency", 64'(first),     64'(exp_first));
    check_eq("tx_stable",   64'(bad_stall), 64'(0));
    check_eq("rx_blocked",  64'(bad_rx),    64'(0));
    for (int i = 0; i < got.size(); i++)
      check_eq($sformatf("rsp_byte%0d", i), 64'(got[i]), 64'(exp_rsp[i]));
    check_eq("idle_rx_ready", 64'(bus.rx_ready_o), 64'(1));
    check_eq("idle_busy",     64'(bus.busy_o),     64'(0));
    check_eq("idle_tx_valid", 64'(bus.tx_valid_o), 64'(0));
  endtask

  task automatic gap_test();
    int bad;
    bad = 0;
    send_frame(8'($urandom_range(1, 255)), $urandom, $urandom, 4);
    check_eq("gap_busy", 64'(bus.busy_o), 64'(1));
    repeat (40) begin
      if (bus.dbg_cmd_o != 8'h00 || bus.tx_valid_o) bad++;
      @(negedge clk);
    end
    check_eq("gap_silent",  64'(bad),        64'(0));
    check_eq("gap_dropped", 64'(bus.busy_o), 64'(0));
    run_txn(8'h01, 32'hCAFE_0040, 32'h0, 4, 0, $urandom);
  endtask

  task automatic reset_test();
    logic [7:0] cmd;
    int         bad;
    cmd = 8'h5A;
    bad = 0;
    send_frame(cmd, $urandom, $urandom, 9);
    repeat (3) @(negedge clk);
    check_eq("rst_pre_cmd", 64'(bus.dbg_cmd_o), 64'(cmd));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_cmd",      64'(bus.dbg_cmd_o),  64'(0));
    check_eq("rst_addr",     64'(bus.dbg_addr_o), 64'(0));
    check_eq("rst_tx_valid", 64'(bus.tx_valid_o), 64'(0));
    check_eq("rst_rx_ready", 64'(bus.rx_ready_o), 64'(1));
    check_eq("rst_busy",     64'(bus.busy_o),     64'(0));
    bus.tx_ready_i = 1'b1;
    repeat (30) begin
      if (bus.tx_valid_o || bus.dbg_cmd_o != 8'h00) bad++;
      @(negedge clk);
    end
    bus.tx_ready_i = 1'b0;
    check_eq("rst_no_rsp", 64'(bad), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_data_i   = 8'h00;
    bus.rx_valid_i  = 1'b0;
    bus.tx_ready_i  = 1'b0;
    bus.dbg_data_i  = 32'h0;
    bus.dbg_ready_i = 1'b0;
    rst             = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_rx_ready", 64'(bus.rx_ready_o), 64'(1));
    check_eq("reset_tx_valid", 64'(bus.tx_valid_o), 64'(0));
    check_eq("reset_tx_data",  64'(bus.tx_data_o),  64'(0));
    check_eq("reset_cmd",      64'(bus.dbg_cmd_o),  64'(0));
    check_eq("reset_addr",     64'(bus.dbg_addr_o), 64'(0));
    check_eq("reset_data",     64'(bus.dbg_data_o), 64'(0));
    check_eq("reset_busy",     64'(bus.busy_o),     64'(0));
    rst = 1'b0;
    @(negedge clk);

    run_txn(8'h01, 32'h0001_0004, 32'h0,         3,  0, 32'hDEAD_BEEF);
    run_txn(8'h02, 32'h0000_0010, 32'h1234_5678, 2,  1, $urandom);
    run_txn(8'h01, $urandom,      32'h0,         20, 0, $urandom);
    run_txn(8'h00, $urandom,      $urandom,      3,  0, $urandom);
    run_txn(8'h03, $urandom,      $urandom,      TMO,     2, $urandom);
    run_txn(8'h04, $urandom,      $urandom,      TMO + 1, 0, $urandom);
    run_txn(8'h01, $urandom,      $urandom,      1,  0, $urandom);
    gap_test();
    reset_test();
    run_txn(8'h01, 32'h0000_0100, 32'h0, 5, 0, 32'hA5A5_0F0F);

    for (int n = 0; n < 30; n++) begin
      logic [7:0] c;
      c = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      run_txn(c, $urandom, $urandom, $urandom_range(1, TMO + 4), $urandom_range(0, 2), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
